alu_issue_ctrl: RTL and testbench

//  Issuing side of the MIPSALU interface. Accepts one ALU request per handshake and decodes

---
 rtl/alu_issue_ctrl_if.sv | 38 +++
 rtl/alu_issue_ctrl.sv | 118 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Request, response and MIPSALU-side signals of the ALU issue controller.
// The slave modport is the controller; the master modport is its environment.
interface alu_issue_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_aluop;
  logic [5:0]        req_funct;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;

  logic [3:0]        alu_ctl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_out;
  logic              alu_zero;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_illegal;

  modport slave (
    input  req_valid, req_aluop, req_funct, req_a, req_b,
    input  alu_out, alu_zero, rsp_ready,
    output req_ready, alu_ctl, alu_a, alu_b,
    output rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );

  modport master (
    output req_valid, req_aluop, req_funct, req_a, req_b,
    output alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_ctl, alu_a, alu_b,
    input  rsp_valid, rsp_result, rsp_zero, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issues one decoded ALU operation per handshake to an external combinational MIPSALU
// and returns the captured result on a valid/ready response channel.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_issue_ctrl_if.slave    bus,
  output logic [COUNT_W-1:0] ops_done
);

  localparam int unsigned CTL_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CTL_W-1:0] dec_ctl;
  logic             dec_legal;
  logic             accept;
  logic             consume;

  // ALUOp/funct to ALUctl decode; anything unlisted is illegal
  always_comb begin
    dec_ctl   = CTL_W'(0);
    dec_legal = 1'b0;
    case (bus.req_aluop)
      2'b00: begin dec_ctl = 4'b0010; dec_legal = 1'b1; end
      2'b01: begin dec_ctl = 4'b0110; dec_legal = 1'b1; end
      2'b10: begin
        case (bus.req_funct)
          6'h20: begin dec_ctl = 4'b0010; dec_legal = 1'b1; end
          6'h22: begin dec_ctl = 4'b0110; dec_legal = 1'b1; end
          6'h24: begin dec_ctl = 4'b0000; dec_legal = 1'b1; end
          6'h25: begin dec_ctl = 4'b0001; dec_legal = 1'b1; end
          6'h27: begin dec_ctl = 4'b1100; dec_legal = 1'b1; end
          6'h2A: begin dec_ctl = 4'b0111; dec_legal = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // req_ready is high exactly in IDLE, so req_valid alone qualifies an accept there
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    consume = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = dec_legal ? EXEC : RESP;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs; handshake flags track the next state so they are valid from the edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.req_ready   <= 1'b1;
      bus.rsp_valid   <= 1'b0;
      bus.alu_ctl     <= CTL_W'(0);
      bus.alu_a       <= DATA_W'(0);
      bus.alu_b       <= DATA_W'(0);
      bus.rsp_result  <= DATA_W'(0);
      bus.rsp_zero    <= 1'b0;
      bus.rsp_illegal <= 1'b0;
      ops_done        <= COUNT_W'(0);
    end else begin
      bus.req_ready <= (state_d == IDLE);
      bus.rsp_valid <= (state_d == RESP);

      if (accept && dec_legal) begin
        bus.alu_ctl <= dec_ctl;
        bus.alu_a   <= bus.req_a;
        bus.alu_b   <= bus.req_b;
      end

      if (accept && !dec_legal) begin
        bus.rsp_result  <= DATA_W'(0);
        bus.rsp_zero    <= 1'b0;
        bus.rsp_illegal <= 1'b1;
      end

      // ALU inputs have been stable for the whole EXEC cycle
      if (state_q == EXEC) begin
        bus.rsp_result  <= bus.alu_out;
        bus.rsp_zero    <= bus.alu_zero;
        bus.rsp_illegal <= 1'b0;
      end

      if (consume && (ops_done != {COUNT_W{1'b1}}))
        ops_done <= ops_done + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural MIPSALU on the ALU side.
module tb_alu_issue_ctrl;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned COUNT_W = 16;

  logic               clk;
  logic               rst_n;
  logic [COUNT_W-1:0] ops_done;

  int n_checks;
  int n_fail;
  int exp_ops;

  alu_issue_ctrl_if #(.DATA_W(DATA_W)) bus ();

  alu_issue_ctrl #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .ops_done (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference MIPSALU, combinational
  always_comb begin
    case (bus.alu_ctl)
      4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
      4'b0001: bus.alu_out = bus.alu_a | bus.alu_b;
      4'b0010: bus.alu_out = bus.alu_a + bus.alu_b;
      4'b0110: bus.alu_out = bus.alu_a - bus.alu_b;
      4'b0111: bus.alu_out = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
      4'b1100: bus.alu_out = ~(bus.alu_a | bus.alu_b);
      default: bus.alu_out = 32'd0;
    endcase
    bus.alu_zero = (bus.alu_out == 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request while in IDLE and drop it after the accepting edge
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b);
    bus.req_aluop = op;
    bus.req_funct = fn;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    step();
    bus.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready);
    end
    n_checks++;
    if (bus.rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid);
    end
    n_checks++;
    if (bus.alu_ctl !== 4'b0000 || bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin
      n_fail++; $display("FAIL reset_alu: got ctl=%b a=%h b=%h expected all 0",
                         bus.alu_ctl, bus.alu_a, bus.alu_b);
    end
    n_checks++;
    if (bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp: got res=%h z=%b ill=%b expected 0",
                         bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
    end
    n_checks++;
    if (ops_done !== 16'd0) begin
      n_fail++; $display("FAIL reset_ops_done: got %0d expected 0", ops_done);
    end
  endtask

  task automatic test_legal_ops();
    logic [1:0]  op  [8] = '{2'b10, 2'b01, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [5:0]  fn  [8] = '{6'h24, 6'h3F, 6'h2A, 6'h3F, 6'h20, 6'h22, 6'h27, 6'h25};
    logic [31:0] a   [8] = '{32'h0000000F, 32'h0000000F, 32'h00000003, 32'h7FFFFFFF,
                             32'h00000010, 32'h00000003, 32'h0000000F, 32'h0000000F};
    logic [31:0] b   [8] = '{32'h00000003, 32'h0000000F, 32'h0000000F, 32'h00000001,
                             32'h00000020, 32'h0000000F, 32'h00000003, 32'h00000003};
    logic [3:0]  ctl [8] = '{4'b0000, 4'b0110, 4'b0111, 4'b0010,
                             4'b0010, 4'b0110, 4'b1100, 4'b0001};
    logic [31:0] res [8] = '{32'h00000003, 32'h00000000, 32'h00000001, 32'h80000000,
                             32'h00000030, 32'hFFFFFFF4, 32'hFFFFFFF0, 32'h0000000F};
    logic        zr  [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      send(op[i], fn[i], a[i], b[i]);
      n_checks++;
      if (bus.alu_ctl !== ctl[i] || bus.alu_a !== a[i] || bus.alu_b !== b[i]) begin
        n_fail++; $display("FAIL legal%0d_alu: got ctl=%b a=%h b=%h expected ctl=%b a=%h b=%h",
                           i, bus.alu_ctl, bus.alu_a, bus.alu_b, ctl[i], a[i], b[i]);
      end
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
        n_fail++; $display("FAIL legal%0d_exec_flags: got rsp_valid=%b req_ready=%b expected 0 0",
                           i, bus.rsp_valid, bus.req_ready);
      end
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== res[i] ||
          bus.rsp_zero !== zr[i] || bus.rsp_illegal !== 1'b0) begin
        n_fail++; $display("FAIL legal%0d_rsp: got v=%b res=%h z=%b ill=%b expected v=1 res=%h z=%b ill=0",
                           i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal,
                           res[i], zr[i]);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      exp_ops++;
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || ops_done !== 16'(exp_ops)) begin
        n_fail++; $display("FAIL legal%0d_done: got v=%b rdy=%b ops=%0d expected v=0 rdy=1 ops=%0d",
                           i, bus.rsp_valid, bus.req_ready, ops_done, exp_ops);
      end
    end
  endtask

  // Runs after test_legal_ops, whose last accepted op was OR with A=F, B=3
  task automatic test_illegal();
    logic [1:0] op [2] = '{2'b10, 2'b11};
    logic [5:0] fn [2] = '{6'h00, 6'h20};
    for (int i = 0; i < 2; i++) begin
      send(op[i], fn[i], 32'h12345678, 32'h9ABCDEF0);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_illegal !== 1'b1 ||
          bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b0) begin
        n_fail++; $display("FAIL illegal%0d_rsp: got v=%b ill=%b res=%h z=%b expected v=1 ill=1 res=0 z=0",
                           i, bus.rsp_valid, bus.rsp_illegal, bus.rsp_result, bus.rsp_zero);
      end
      n_checks++;
      if (bus.alu_ctl !== 4'b0001 || bus.alu_a !== 32'h0000000F || bus.alu_b !== 32'h00000003) begin
        n_fail++; $display("FAIL illegal%0d_alu_hold: got ctl=%b a=%h b=%h expected ctl=0001 a=f b=3",
                           i, bus.alu_ctl, bus.alu_a, bus.alu_b);
      end
      bus.rsp_ready = 1'b1;
      step();
      bus.rsp_ready = 1'b0;
      exp_ops++;
      n_checks++;
      if (ops_done !== 16'(exp_ops) || bus.req_ready !== 1'b1) begin
        n_fail++; $display("FAIL illegal%0d_done: got ops=%0d rdy=%b expected ops=%0d rdy=1",
                           i, ops_done, bus.req_ready, exp_ops);
      end
    end
  endtask

  task automatic test_back_to_back();
    send(2'b00, 6'h00, 32'd5, 32'd7);
    bus.req_aluop = 2'b01;
    bus.req_funct = 6'h00;
    bus.req_a     = 32'd9;
    bus.req_b     = 32'd9;
    bus.req_valid = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0 ||
          bus.req_ready !== 1'b0 || bus.alu_a !== 32'd5 || ops_done !== 16'(exp_ops)) begin
        n_fail++; $display("FAIL stall%0d: got v=%b res=%h z=%b rdy=%b a=%h ops=%0d expected v=1 res=c z=0 rdy=0 a=5 ops=%0d",
                           i, bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.req_ready,
                           bus.alu_a, ops_done, exp_ops);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_ops++;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || ops_done !== 16'(exp_ops)) begin
      n_fail++; $display("FAIL stall_release: got rdy=%b v=%b ops=%0d expected rdy=1 v=0 ops=%0d",
                         bus.req_ready, bus.rsp_valid, ops_done, exp_ops);
    end
    step();
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.alu_ctl !== 4'b0110 || bus.alu_a !== 32'd9 || bus.req_ready !== 1'b0) begin
      n_fail++; $display("FAIL held_req_accept: got ctl=%b a=%h rdy=%b expected ctl=0110 a=9 rdy=0",
                         bus.alu_ctl, bus.alu_a, bus.req_ready);
    end
    step();
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'd0 || bus.rsp_zero !== 1'b1) begin
      n_fail++; $display("FAIL held_req_rsp: got v=%b res=%h z=%b expected v=1 res=0 z=1",
                         bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    exp_ops++;
    n_checks++;
    if (ops_done !== 16'(exp_ops)) begin
      n_fail++; $display("FAIL held_req_ops: got %0d expected %0d", ops_done, exp_ops);
    end
  endtask

  task automatic test_reset_mid_exec();
    send(2'b00, 6'h00, 32'h000000AA, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    exp_ops = 0;
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || ops_done !== 16'd0) begin
      n_fail++; $display("FAIL async_reset_flags: got rdy=%b v=%b ops=%0d expected rdy=1 v=0 ops=0",
                         bus.req_ready, bus.rsp_valid, ops_done);
    end
    n_checks++;
    if (bus.alu_ctl !== 4'b0000 || bus.alu_a !== 32'd0 || bus.rsp_result !== 32'd0) begin
      n_fail++; $display("FAIL async_reset_data: got ctl=%b a=%h res=%h expected 0",
                         bus.alu_ctl, bus.alu_a, bus.rsp_result);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || ops_done !== 16'd0) begin
        n_fail++; $display("FAIL dropped_req%0d: got v=%b rdy=%b ops=%0d expected v=0 rdy=1 ops=0",
                           i, bus.rsp_valid, bus.req_ready, ops_done);
      end
    end
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    exp_ops       = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_aluop = 2'b00;
    bus.req_funct = 6'h00;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.rsp_ready = 1'b0;
    step();
    step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_legal_ops();
    test_illegal();
    test_back_to_back();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
